// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: steps A,B,C through 000..111, samples Y1..Y3
// per vector and compares the captured tables against golden tables.
module truth_table_sequencer #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [7:0] EXP_Y1        = 8'hE8,
  parameter logic [7:0] EXP_Y2        = 8'h96,
  parameter logic [7:0] EXP_Y3        = 8'h80
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       Y1,
  input  logic       Y2,
  input  logic       Y3,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] mismatch_count,
  output logic [2:0] first_fail_idx,
  output logic [7:0] tt_y1,
  output logic [7:0] tt_y2,
  output logic [7:0] tt_y3
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [3:0] cnt, cnt_n;
  logic [2:0] abc, abc_n;
  logic       busy_n, done_n, pass_n;
  logic [3:0] mc_n;
  logic [2:0] ffi_n;
  logic [7:0] tt1_n, tt2_n, tt3_n;
  logic       miss;

  assign {A, B, C} = abc;

  assign miss = (Y1 != EXP_Y1[idx])
              | (Y2 != EXP_Y2[idx])
              | (Y3 != EXP_Y3[idx]);

  // Next-state, stimulus and result-update logic
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    abc_n   = abc;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    mc_n    = mismatch_count;
    ffi_n   = first_fail_idx;
    tt1_n   = tt_y1;
    tt2_n   = tt_y2;
    tt3_n   = tt_y3;
    unique case (state)
      IDLE: begin
        abc_n  = 3'd0;
        busy_n = 1'b0;
        if (start) begin
          state_n = DRIVE;
          idx_n   = 3'd0;
          cnt_n   = 4'd0;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          mc_n    = 4'd0;
          ffi_n   = 3'd0;
          tt1_n   = 8'd0;
          tt2_n   = 8'd0;
          tt3_n   = 8'd0;
        end
      end
      DRIVE: begin
        cnt_n = cnt + 4'd1;
        if (cnt == 4'(SETTLE_CYCLES - 1))
          state_n = SAMPLE;
      end
      SAMPLE: begin
        tt1_n[idx] = Y1;
        tt2_n[idx] = Y2;
        tt3_n[idx] = Y3;
        if (miss) begin
          mc_n = mismatch_count + 4'd1;
          if (mismatch_count == 4'd0)
            ffi_n = idx;
        end
        if (idx == 3'd7) begin
          state_n = DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          abc_n   = 3'd0;
          pass_n  = (mc_n == 4'd0);
        end else begin
          state_n = DRIVE;
          idx_n   = idx + 3'd1;
          cnt_n   = 4'd0;
          abc_n   = idx + 3'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        abc_n   = 3'd0;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any run in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 3'd0;
      cnt            <= 4'd0;
      abc            <= 3'd0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= 4'd0;
      first_fail_idx <= 3'd0;
      tt_y1          <= 8'd0;
      tt_y2          <= 8'd0;
      tt_y3          <= 8'd0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      cnt            <= cnt_n;
      abc            <= abc_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      mismatch_count <= mc_n;
      first_fail_idx <= ffi_n;
      tt_y1          <= tt1_n;
      tt_y2          <= tt2_n;
      tt_y3          <= tt3_n;
    end
  end

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: directed runs, expected results
// queued at start, checked by per-DUT monitors on the done pulse.
module tb_truth_table_sequencer;

  localparam int S0 = 2;
  localparam int S1 = 1;

  typedef struct {
    int         acc;
    bit         pass;
    logic [3:0] cnt;
    logic [2:0] ffi;
    logic [7:0] t1;
    logic [7:0] t2;
    logic [7:0] t3;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic inv2 = 1'b0;
  logic tie3 = 1'b0;

  logic y1_0, y2_0, y3_0, a0, b0, c0;
  logic busy0, done0, pass0;
  logic [3:0] cnt0;
  logic [2:0] ffi0;
  logic [7:0] t1_0, t2_0, t3_0;

  logic y1_1, y2_1, y3_1, a1, b1, c1;
  logic busy1, done1, pass1;
  logic [3:0] cnt1;
  logic [2:0] ffi1;
  logic [7:0] t1_1, t2_1, t3_1;

  int   tick = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  always @(posedge clk) tick <= tick + 1;

  // Combinational block under test, with fault knobs for DUT0
  always_comb begin
    y1_0 = (a0 & b0) | (a0 & c0) | (b0 & c0);
    y2_0 = a0 ^ b0 ^ c0 ^ inv2;
    y3_0 = a0 & b0 & c0 & ~tie3;
    y1_1 = (a1 & b1) | (a1 & c1) | (b1 & c1);
    y2_1 = a1 ^ b1 ^ c1;
    y3_1 = a1 & b1 & c1;
  end

  truth_table_sequencer #(.SETTLE_CYCLES(S0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .Y1(y1_0), .Y2(y2_0), .Y3(y3_0),
    .A(a0), .B(b0), .C(c0),
    .busy(busy0), .done(done0), .pass(pass0),
    .mismatch_count(cnt0), .first_fail_idx(ffi0),
    .tt_y1(t1_0), .tt_y2(t2_0), .tt_y3(t3_0)
  );

  truth_table_sequencer #(.SETTLE_CYCLES(S1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .Y1(y1_1), .Y2(y2_1), .Y3(y3_1),
    .A(a1), .B(b1), .C(c1),
    .busy(busy1), .done(done1), .pass(pass1),
    .mismatch_count(cnt1), .first_fail_idx(ffi1),
    .tt_y1(t1_1), .tt_y2(t2_1), .tt_y3(t3_1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0d", nm, act, exp, tick);
    end
  endtask

  function automatic exp_t mk(bit p, logic [3:0] c, logic [2:0] f,
                              logic [7:0] a, logic [7:0] b,
                              logic [7:0] d);
    exp_t e;
    e.acc = 0;
    e.pass = p;
    e.cnt = c;
    e.ffi = f;
    e.t1 = a;
    e.t2 = b;
    e.t3 = d;
    return e;
  endfunction

  // Monitor for DUT0
  always @(negedge clk) begin
    int k;
    exp_t e;
    if (rst_n) begin
      if (q0.size() > 0) begin
        k = tick - q0[0].acc;
        if (k >= 1 && k <= 8 * (S0 + 1)) begin
          chk("busy0", busy0, 1);
          chk("abc0", {a0, b0, c0}, (k - 1) / (S0 + 1));
          chk("pass0_run", pass0, 0);
        end
      end
      if (done0) begin
        if (q0.size() == 0) begin
          chk("done0_unexpected", 1, 0);
        end else begin
          e = q0.pop_front();
          chk("done0_cycle", tick - e.acc, 8 * (S0 + 1) + 1);
          chk("busy0_done", busy0, 0);
          chk("abc0_done", {a0, b0, c0}, 0);
          chk("pass0", pass0, e.pass);
          chk("cnt0", cnt0, e.cnt);
          chk("ffi0", ffi0, e.ffi);
          chk("tt_y1_0", t1_0, e.t1);
          chk("tt_y2_0", t2_0, e.t2);
          chk("tt_y3_0", t3_0, e.t3);
        end
      end
    end
  end

  // Monitor for DUT1
  always @(negedge clk) begin
    int k;
    exp_t e;
    if (rst_n) begin
      if (q1.size() > 0) begin
        k = tick - q1[0].acc;
        if (k >= 1 && k <= 8 * (S1 + 1)) begin
          chk("busy1", busy1, 1);
          chk("abc1", {a1, b1, c1}, (k - 1) / (S1 + 1));
        end
      end
      if (done1) begin
        if (q1.size() == 0) begin
          chk("done1_unexpected", 1, 0);
        end else begin
          e = q1.pop_front();
          chk("done1_cycle", tick - e.acc, 8 * (S1 + 1) + 1);
          chk("pass1", pass1, e.pass);
          chk("cnt1", cnt1, e.cnt);
          chk("ffi1", ffi1, e.ffi);
          chk("tt_y1_1", t1_1, e.t1);
          chk("tt_y2_1", t2_1, e.t2);
          chk("tt_y3_1", t3_1, e.t3);
        end
      end
    end
  end

  task automatic go0(input exp_t e);
    @(negedge clk);
    start0 = 1'b1;
    e.acc = tick;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait0();
    for (int i = 0; i < 200; i++) begin
      if (q0.size() == 0) break;
      @(negedge clk);
    end
    if (q0.size() != 0) begin
      chk("timeout0", 1, 0);
      q0.delete();
    end
  endtask

  task automatic wait_k0(input int acc, input int k);
    for (int i = 0; i < 100; i++) begin
      if (tick - acc >= k) break;
      @(negedge clk);
    end
  endtask

  task automatic chk_zero0(input string nm);
    chk({nm, "_abc"}, {a0, b0, c0}, 0);
    chk({nm, "_busy"}, busy0, 0);
    chk({nm, "_done"}, done0, 0);
    chk({nm, "_pass"}, pass0, 0);
    chk({nm, "_cnt"}, cnt0, 0);
    chk({nm, "_ffi"}, ffi0, 0);
    chk({nm, "_tt"}, {t1_0, t2_0, t3_0}, 0);
  endtask

  initial begin
    exp_t good, e;
    int   acc;
    good = mk(1'b1, 4'd0, 3'd0, 8'hE8, 8'h96, 8'h80);

    #1;
    chk_zero0("reset0");
    chk("reset1_busy", busy1, 0);
    chk("reset1_tt", {t1_1, t2_1, t3_1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Correct model
    go0(good);
    wait0();

    // Y3 stuck low: only vector 7 differs
    tie3 = 1'b1;
    go0(mk(1'b0, 4'd1, 3'd7, 8'hE8, 8'h96, 8'h00));
    wait0();
    repeat (4) @(negedge clk);
    chk("hold_pass", pass0, 0);
    chk("hold_cnt", cnt0, 1);
    chk("hold_ffi", ffi0, 7);
    tie3 = 1'b0;

    // Y2 inverted: every vector differs
    inv2 = 1'b1;
    go0(mk(1'b0, 4'd8, 3'd0, 8'hE8, 8'h69, 8'h80));
    wait0();
    inv2 = 1'b0;

    // Start pulses during a run are ignored
    go0(good);
    acc = q0[0].acc;
    wait_k0(acc, 5);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_k0(acc, 12);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait0();
    repeat (8) @(negedge clk);
    chk("idle_busy", busy0, 0);

    // Start held high re-triggers from the IDLE cycle after DONE
    @(negedge clk);
    start0 = 1'b1;
    e = good;
    e.acc = tick;
    q0.push_back(e);
    e.acc = tick + 8 * (S0 + 1) + 2;
    q0.push_back(e);
    wait_k0(e.acc, 1);
    start0 = 1'b0;
    wait0();

    // Reset mid-run at vector 3
    go0(good);
    acc = q0[0].acc;
    wait_k0(acc, 10);
    rst_n = 1'b0;
    #1;
    chk_zero0("abort");
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    go0(good);
    wait0();

    // Short settle interval on DUT1
    @(negedge clk);
    start1 = 1'b1;
    e = good;
    e.acc = tick;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q1.size() == 0) break;
      @(negedge clk);
    end
    if (q1.size() != 0) begin
      chk("timeout1", 1, 0);
      q1.delete();
    end

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
